// File: rtl/scan_pkg.sv
// Shared definitions for the scan address sequencer: state encodings,
// default widths and terminal-address helpers.
package scan_pkg;

  // Sequencer states; BLANK is only reachable when SCAN_BLANK_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  localparam int ADDR_W_DEF  = 3;
  localparam int DWELL_W_DEF = 16;

  // First address of a sweep: all-ones when counting down, zero when counting up.
  function automatic logic [31:0] first_addr(input logic down, input int w);
    return down ? ((32'd1 << w) - 32'd1) : 32'd0;
  endfunction

  // The last address of a sweep is the first address of the opposite direction.
  function automatic logic is_terminal(input logic [31:0] addr, input logic down, input int w);
    return addr == first_addr(!down, w);
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable dwell counter: clears on clr_i, counts on en_i, and flags when the
// count has reached the programmed limit.
module scan_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] limit_i,
  output logic               tc_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/scan_addr_seq.sv
// Scan address sequencer feeding a one-hot select decoder. Steps through all
// 2^ADDR_W codes up or down, holding each for dwell+1 cycles, in single-sweep
// or continuous mode. Optional macro SCAN_BLANK_EN inserts one blank cycle
// (addr_valid low, old addr held) before every address change.
module scan_addr_seq
  import scan_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic               dir_down,
  input  logic [DWELL_W-1:0] dwell,
  output logic [ADDR_W-1:0]  addr,
  output logic               addr_valid,
  output logic               busy,
  output logic               done,
  output logic               tick
);

  scan_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_q, tick_d;
  logic               cont_q, cont_d;
  logic               down_q, down_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               tmr_clr;
  logic               tmr_en;
  logic               tmr_tc;
  logic [ADDR_W-1:0]  addr_step;
  logic               at_terminal;

  scan_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (dwell_q),
    .tc_o    (tmr_tc)
  );

  // Next address wraps naturally modulo 2^ADDR_W.
  assign addr_step   = down_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
  assign at_terminal = is_terminal(32'(addr_q), down_q, ADDR_W);

  // Next-state, address and handshake decisions; stop beats advance/completion.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tick_d  = 1'b0;
    cont_d  = cont_q;
    down_d  = down_q;
    dwell_d = dwell_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start && !stop) begin
          cont_d  = continuous;
          down_d  = dir_down;
          dwell_d = dwell;
          addr_d  = ADDR_W'(first_addr(dir_down, ADDR_W));
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop) begin
          tmr_clr = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          tmr_clr = 1'b1;
          if (at_terminal && !cont_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
`ifdef SCAN_BLANK_EN
            valid_d = 1'b0;
            state_d = ST_BLANK;
`else
            addr_d  = addr_step;
            tick_d  = 1'b1;
`endif
          end
        end else begin
          tmr_en = 1'b1;
        end
      end

`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        tmr_clr = 1'b1;
        if (stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_step;
          tick_d  = 1'b1;
          valid_d = 1'b1;
          state_d = ST_RUN;
        end
      end
`endif

      default: begin
        tmr_clr = 1'b1;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address, configuration and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      cont_q  <= 1'b0;
      down_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      cont_q  <= cont_d;
      down_q  <= down_d;
      dwell_q <= dwell_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_scan_addr_seq.sv
// Scoreboard bench for scan_addr_seq: stimulus pushes the expected per-cycle
// output records, a monitor pops one whenever the sequencer is active.
module tb_scan_addr_seq;

`ifdef SCAN_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic        dir_down = 1'b0;
  logic [15:0] dwell = '0;
  logic [2:0]  addr;
  logic        addr_valid;
  logic        busy;
  logic        done;
  logic        tick;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] addr;
    logic       valid;
    logic       busy;
    logic       tick;
    logic       done;
  } rec_t;

  rec_t exp_q[$];

  scan_addr_seq #(.ADDR_W(3), .DWELL_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .dir_down   (dir_down),
    .dwell      (dwell),
    .addr       (addr),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // Monitor: one record per active cycle (valid, busy or done high).
  always @(negedge clk) begin
    rec_t act;
    rec_t e;
    act = '{addr: addr, valid: addr_valid, busy: busy, tick: tick, done: done};
    if (addr_valid === 1'b1 || busy === 1'b1 || done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output t=%0t got addr=%0d valid=%0b busy=%0b tick=%0b done=%0b, expected idle",
                 $time, act.addr, act.valid, act.busy, act.tick, act.done);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL seq t=%0t got addr=%0d valid=%0b busy=%0b tick=%0b done=%0b, expected addr=%0d valid=%0b busy=%0b tick=%0b done=%0b",
                   $time, act.addr, act.valid, act.busy, act.tick, act.done,
                   e.addr, e.valid, e.busy, e.tick, e.done);
        end else begin
          $display("ok t=%0t addr=%0d valid=%0b busy=%0b tick=%0b done=%0b",
                   $time, act.addr, act.valid, act.busy, act.tick, act.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok %s = %0d", name, act);
    end
  endtask

  // Push the expected cycle records of a sweep, at most max_n of them.
  task automatic gen(input int dw, input bit dn, input bit cont, input int max_n);
    int n;
    logic [2:0] a;
    bit term;
    n = 0;
    a = dn ? 3'd7 : 3'd0;
    for (int step = 0; n < max_n; step++) begin
      for (int j = 0; j <= dw && n < max_n; j++) begin
        exp_q.push_back('{addr: a, valid: 1'b1, busy: 1'b1, tick: (j == 0 && step > 0), done: 1'b0});
        n++;
      end
      if (n >= max_n) break;
      term = dn ? (a == 3'd0) : (a == 3'd7);
      if (term && !cont) begin
        exp_q.push_back('{addr: a, valid: 1'b0, busy: 1'b0, tick: 1'b0, done: 1'b1});
        n++;
        break;
      end
      if (BL != 0) begin
        exp_q.push_back('{addr: a, valid: 1'b0, busy: 1'b1, tick: 1'b0, done: 1'b0});
        n++;
      end
      a = dn ? a - 3'd1 : a + 3'd1;
    end
  endtask

  // Called at posedge+1; start is sampled on the next edge.
  task automatic do_start(input int dw, input bit dn, input bit cont);
    dwell = 16'(dw);
    dir_down = dn;
    continuous = cont;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_idle(input string name, input logic [2:0] a);
    chk({name, "_addr"}, addr, a);
    chk({name, "_valid"}, addr_valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_tick"}, tick, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset", 3'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single up sweep, dwell 0.
    gen(0, 1'b0, 1'b0, 1000);
    do_start(0, 1'b0, 1'b0);
    wait_drain("up_d0");
    repeat (2) @(posedge clk);
    #1;

    // Single down sweep, dwell 2, with a start and input changes mid-sweep.
    gen(2, 1'b1, 1'b0, 1000);
    do_start(2, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    dwell = 16'd0;
    dir_down = 1'b0;
    continuous = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain("down_d2");
    chk_idle("down_d2_end", 3'd0);
    repeat (2) @(posedge clk);
    #1;

    // Continuous up, dwell 1: wrap once, stop at first cycle of addr 3 on lap 2.
    n = 1 + 11 * (2 + BL);
    gen(1, 1'b0, 1'b1, n);
    do_start(1, 1'b0, 1'b1);
    repeat (n - 1) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    chk_idle("stop", 3'd3);
    chk("stop_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    // start together with stop in IDLE is ignored.
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("start_stop", 3'd3);

    // Reset mid-sweep at addr 5.
    n = 1 + 5 * (1 + BL);
    gen(0, 1'b0, 1'b0, n);
    do_start(0, 1'b0, 1'b0);
    repeat (n - 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("mid_reset", 3'd0);
    chk("mid_reset_drained", exp_q.size(), 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
